// File: rtl/load_store_unit.sv
// Data-memory access stage: aligns stores, extends loads, runs one req/ack bus transaction.
// Latency >= 3 cycles (issue, REQ until ack or timeout, DONE); stall holds the core while the access is open.
module load_store_unit #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state_q, state_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [3:0]       bus_be_q, bus_be_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [31:0]      read_data_q, read_data_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       a_q, a_d;

  logic        legal_f3, aligned, valid;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  always_comb begin
    legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (mem_read && ((funct3 == 3'b100) || (funct3 == 3'b101)));
    aligned  = (funct3[1:0] == 2'b00) ||
               ((funct3[1:0] == 2'b01) && !address[0]) ||
               ((funct3[1:0] == 2'b10) && (address[1:0] == 2'b00));
    valid    = (mem_read ^ mem_write) && legal_f3 && aligned;
  end

  // Lane extraction uses the offset latched at issue, not the live address.
  always_comb begin
    case (a_q)
      2'd0:    byte_sel = bus_rdata[7:0];
      2'd1:    byte_sel = bus_rdata[15:8];
      2'd2:    byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    half_sel = a_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'd0, byte_sel};
      3'b101:  load_val = {16'd0, half_sel};
      default: load_val = bus_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    read_data_d = read_data_q;
    fault_d     = 1'b0;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    a_d         = a_q;
    stall       = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid) begin
          stall       = 1'b1;
          state_d     = REQ;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write;
          bus_addr_d  = {address[31:2], 2'b00};
          cnt_d       = '0;
          f3_d        = funct3;
          a_d         = address[1:0];
          bus_be_d    = 4'b1111;
          bus_wdata_d = write_data;
          if (mem_write) begin
            case (funct3[1:0])
              2'b00: begin
                bus_be_d    = 4'b0001 << address[1:0];
                bus_wdata_d = {4{write_data[7:0]}};
              end
              2'b01: begin
                bus_be_d    = 4'b0011 << {address[1], 1'b0};
                bus_wdata_d = {2{write_data[15:0]}};
              end
              default: ;
            endcase
          end
        end else if (mem_read || mem_write) begin
          fault_d = 1'b1;
        end
      end
      REQ: begin
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (bus_ack) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          if (!bus_we_q) read_data_d = load_val;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          fault_d   = 1'b1;
          if (!bus_we_q) read_data_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      read_data_q <= '0;
      fault_q     <= 1'b0;
      cnt_q       <= '0;
      f3_q        <= '0;
      a_q         <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      read_data_q <= read_data_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      a_q         <= a_d;
    end
  end

  assign read_data = read_data_q;
  assign fault     = fault_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a short timeout so the abort path is reachable.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        stall, fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int req_cycles;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .address(address), .write_data(write_data), .read_data(read_data),
    .stall(stall), .fault(fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_acc(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    address    = a;
    write_data = wd;
  endtask

  // Load acked in the first REQ cycle; checks the value presented in DONE.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rdata, input logic [31:0] exp);
    set_acc(1'b1, 1'b0, f3, a, 32'h0);
    step();
    bus_ack   = 1'b1;
    bus_rdata = rdata;
    step();
    bus_ack = 1'b0;
    set_acc(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    chk(tag, read_data, exp);
    step();
  endtask

  // Illegal request: no bus cycle, no stall, one-cycle fault pulse.
  task automatic do_bad(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd_exp);
    set_acc(rd, wr, f3, a, 32'h0);
    #1;
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    step();
    set_acc(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    chk({tag, "_req"}, {31'd0, bus_req}, 32'd0);
    chk({tag, "_fault"}, {31'd0, fault}, 32'd1);
    chk({tag, "_rdata"}, read_data, rd_exp);
    step();
    chk({tag, "_fault_end"}, {31'd0, fault}, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    set_acc(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    chk("rst_req",   {31'd0, bus_req}, 32'd0);
    chk("rst_we",    {31'd0, bus_we}, 32'd0);
    chk("rst_be",    {28'd0, bus_be}, 32'd0);
    chk("rst_addr",  bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    step();
    reset = 1'b0;
    step();

    // LW 0x100, ack in the second REQ cycle
    set_acc(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    #1;
    chk("lw_stall_idle", {31'd0, stall}, 32'd1);
    step();
    chk("lw_req1",   {31'd0, bus_req}, 32'd1);
    chk("lw_stall1", {31'd0, stall}, 32'd1);
    chk("lw_addr",   bus_addr, 32'h100);
    chk("lw_be",     {28'd0, bus_be}, 32'hF);
    chk("lw_we",     {31'd0, bus_we}, 32'd0);
    step();
    chk("lw_req2",   {31'd0, bus_req}, 32'd1);
    chk("lw_stall2", {31'd0, stall}, 32'd1);
    bus_ack   = 1'b1;
    bus_rdata = 32'hDEADBEEF;
    step();
    bus_ack = 1'b0;
    set_acc(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    chk("lw_done_stall", {31'd0, stall}, 32'd0);
    chk("lw_done_req",   {31'd0, bus_req}, 32'd0);
    chk("lw_rdata",      read_data, 32'hDEADBEEF);
    step();
    chk("lw_idle_stall", {31'd0, stall}, 32'd0);

    // Lane extraction and extension
    do_load("lb_103",  3'b000, 32'h103, 32'h80FF0011, 32'hFFFFFF80);
    do_load("lbu_103", 3'b100, 32'h103, 32'h80FF0011, 32'h00000080);
    do_load("lhu_102", 3'b101, 32'h102, 32'h80FF0011, 32'h000080FF);
    do_load("lh_102",  3'b001, 32'h102, 32'h80FF0011, 32'hFFFF80FF);
    do_load("lb_100",  3'b000, 32'h100, 32'h80FF0011, 32'h00000011);
    do_load("lh_100",  3'b001, 32'h100, 32'h12348001, 32'hFFFF8001);

    // SB 0x201
    set_acc(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB);
    step();
    chk("sb_addr",  bus_addr, 32'h200);
    chk("sb_be",    {28'd0, bus_be}, 32'h2);
    chk("sb_wdata", bus_wdata, 32'hABABABAB);
    chk("sb_we",    {31'd0, bus_we}, 32'd1);
    bus_ack   = 1'b1;
    bus_rdata = 32'h55555555;
    step();
    bus_ack = 1'b0;
    set_acc(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    chk("sb_rdata_keep", read_data, 32'hFFFF8001);
    step();

    // SH 0x202
    set_acc(1'b0, 1'b1, 3'b001, 32'h202, 32'hCAFE1234);
    step();
    chk("sh_be",    {28'd0, bus_be}, 32'hC);
    chk("sh_wdata", bus_wdata, 32'h12341234);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    set_acc(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    step();

    // Faulting requests
    do_bad("lw_mis",  1'b1, 1'b0, 3'b010, 32'h102, 32'hFFFF8001);
    do_bad("lh_mis",  1'b1, 1'b0, 3'b001, 32'h101, 32'hFFFF8001);
    do_bad("f3_011",  1'b1, 1'b0, 3'b011, 32'h100, 32'hFFFF8001);
    do_bad("rd_wr",   1'b1, 1'b1, 3'b010, 32'h100, 32'hFFFF8001);
    do_bad("sbu",     1'b0, 1'b1, 3'b100, 32'h100, 32'hFFFF8001);

    // bus_ack outside REQ is ignored
    bus_ack   = 1'b1;
    bus_rdata = 32'h12345678;
    step();
    bus_ack = 1'b0;
    chk("idle_ack_rdata", read_data, 32'hFFFF8001);
    chk("idle_ack_req",   {31'd0, bus_req}, 32'd0);

    // Reset while REQ is open
    set_acc(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
    step();
    chk("rreq_req_before", {31'd0, bus_req}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rreq_req_drop", {31'd0, bus_req}, 32'd0);
    set_acc(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    step();
    reset = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'hA5A5A5A5;
    step();
    bus_ack = 1'b0;
    chk("rreq_rdata", read_data, 32'd0);
    chk("rreq_stall", {31'd0, stall}, 32'd0);
    chk("rreq_req",   {31'd0, bus_req}, 32'd0);

    // Load a non-zero value so the timeout clearing is visible
    do_load("lw_pre_to", 3'b010, 32'h500, 32'h0BADF00D, 32'h0BADF00D);

    // Timeout: no ack, TIMEOUT=8
    set_acc(1'b1, 1'b0, 3'b010, 32'h600, 32'h0);
    step();
    req_cycles = 0;
    while (bus_req && req_cycles < 40) begin
      req_cycles++;
      chk("to_stall", {31'd0, stall}, 32'd1);
      step();
    end
    set_acc(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    chk("to_req_cycles", req_cycles, 32'd8);
    chk("to_fault",      {31'd0, fault}, 32'd1);
    chk("to_rdata",      read_data, 32'd0);
    chk("to_done_stall", {31'd0, stall}, 32'd0);
    step();
    chk("to_fault_end",  {31'd0, fault}, 32'd0);
    chk("to_idle_req",   {31'd0, bus_req}, 32'd0);

    // Back to normal operation after the abort
    do_load("lbu_after_to", 3'b100, 32'h701, 32'h0000C300, 32'h000000C3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
